// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jk_pkg
//  Purpose  : Shared definitions for the JK flip-flop library: the 2-bit
//             J/K command encoding ({J,K}) and the elaboration-time legality
//             check for modulo counter parameters.
//  Revision : 1.0  initial release
// ============================================================================
package jk_pkg;

    // {J,K} command encoding applied to a jk_cell
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;

    // A modulo-M counter over W cells needs 2 <= M <= 2^W.
    function automatic bit modulus_ok(input int w, input int m);
        if (w < 1 || w > 30) begin
            return 1'b0;
        end
        return (m >= 2) && (m <= (1 << w));
    endfunction

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : jk_mod_counter_if
//  Purpose  : Control/status bundle of the JK modulo counter.
//  Ports    : en, up, load, load_val[WIDTH], clr_ovf  (controller -> counter)
//             q[WIDTH], tc, ovf                     (counter -> controller)
//  Modports : master (controller side), slave (counter side)
//  Revision : 1.0  initial release
// ============================================================================
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, load_val, clr_ovf,
        input  q, tc, ovf
    );

    modport slave (
        input  en, up, load, load_val, clr_ovf,
        output q, tc, ovf
    );
endinterface : jk_mod_counter_if
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
//  Module   : jk_cell
//  Purpose  : Single JK flip-flop, asynchronous active-high reset to 0.
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous active-high reset
//             i_jk  - {J,K} command (HOLD/RESET/SET/TOGGLE)
//             o_q   - flip-flop output
//  Revision : 1.0  initial release
// ============================================================================
module jk_cell
    import jk_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_jk,
    output logic            o_q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            unique case (i_jk)
                HOLD:    r_q <= r_q;
                RESET:   r_q <= 1'b0;
                SET:     r_q <= 1'b1;
                TOGGLE:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_mod_counter
//  Purpose  : Modulo-MODULUS up/down counter built from WIDTH JK cells.
//             The top computes the next value, encodes it into per-cell
//             J/K commands, produces the cascade terminal count and keeps
//             the sticky overflow flag.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - jk_mod_counter_if.slave (en, up, load, load_val,
//                    clr_ovf in; q, tc, ovf out)
//  Revision : 1.0  initial release
// ============================================================================
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    jk_mod_counter_if.slave   bus
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must lie in 2..2^WIDTH");
    end

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2^WIDTH is representable in the compare
    localparam logic [WIDTH:0]   c_mod = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0]      w_q;
    logic [WIDTH-1:0]      w_next;
    logic [WIDTH-1:0][1:0] w_jk;
    logic                  w_at_max;
    logic                  w_at_zero;
    logic                  w_load_ok;
    logic                  w_set_ovf;
    logic                  r_ovf;

    assign w_at_max  = (w_q == c_max);
    assign w_at_zero = (w_q == '0);
    assign w_load_ok = ({1'b0, bus.load_val} < c_mod);

    // Next value and J/K encoding. Load drives each cell with SET/RESET so
    // the value lands regardless of the current state; counting only
    // toggles the bits that change; everything else holds.
    always_comb begin
        w_next    = w_q;
        w_set_ovf = 1'b0;
        w_jk      = '0;
        if (bus.load) begin
            w_next    = w_load_ok ? bus.load_val : '0;
            w_set_ovf = ~w_load_ok;
            for (int i = 0; i < WIDTH; i++) begin
                w_jk[i] = w_next[i] ? SET : RESET;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                w_next    = w_at_max ? '0 : w_q + 1'b1;
                w_set_ovf = w_at_max;
            end else begin
                w_next    = w_at_zero ? c_max : w_q - 1'b1;
                w_set_ovf = w_at_zero;
            end
            for (int i = 0; i < WIDTH; i++) begin
                w_jk[i] = (w_q[i] ^ w_next[i]) ? TOGGLE : HOLD;
            end
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .i_jk (w_jk[gi]),
            .o_q  (w_q[gi])
        );
    end

    // Sticky overflow: a set event in the same cycle as clr_ovf wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_set_ovf) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.q   = w_q;
    assign bus.ovf = r_ovf;
    assign bus.tc  = bus.en & ~bus.load & ~rst &
                     ((bus.up & w_at_max) | (~bus.up & w_at_zero));

endmodule : jk_mod_counter
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_mod_counter
//  Purpose  : Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10):
//             vector table for load/count/wrap/ovf behaviour plus directed
//             sequences for J/K commands, hold stability and async reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_mod_counter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    jk_mod_counter_if #(.WIDTH(4)) bus ();

    jk_mod_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic       clr;
        logic       tc;    // expected before the edge
        logic [3:0] q;     // expected after the edge
        logic       ovf;   // expected after the edge
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic up, input logic load,
                         input logic [3:0] lv, input logic clr);
        bus.en       = en;
        bus.up       = up;
        bus.load     = load;
        bus.load_val = lv;
        bus.clr_ovf  = clr;
    endtask

    logic [3:0] held;

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        rst = 1'b1;

        //                en  up  ld  lv     clr  tc  q      ovf
        vecs[0]  = '{1'b0,1'b1,1'b1,4'd8, 1'b0,1'b0,4'd8, 1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b0,4'd0, 1'b0,1'b0,4'd9, 1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,4'd0, 1'b0,1'b1,4'd0, 1'b1};
        vecs[3]  = '{1'b1,1'b1,1'b0,4'd0, 1'b1,1'b0,4'd1, 1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b1,4'd1, 1'b0,1'b0,4'd1, 1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,4'd0, 1'b0,1'b0,4'd0, 1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,4'd0, 1'b0,1'b1,4'd9, 1'b1};
        vecs[7]  = '{1'b1,1'b0,1'b0,4'd0, 1'b0,1'b0,4'd8, 1'b1};
        vecs[8]  = '{1'b1,1'b1,1'b1,4'd5, 1'b0,1'b0,4'd5, 1'b1};
        vecs[9]  = '{1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0,4'd5, 1'b0};
        vecs[10] = '{1'b0,1'b1,1'b1,4'd12,1'b0,1'b0,4'd0, 1'b1};
        vecs[11] = '{1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0,4'd0, 1'b0};
        vecs[12] = '{1'b0,1'b1,1'b1,4'd9, 1'b0,1'b0,4'd9, 1'b0};
        vecs[13] = '{1'b1,1'b1,1'b0,4'd0, 1'b1,1'b1,4'd0, 1'b1};
        vecs[14] = '{1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0,4'd0, 1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,4'd0, 1'b0};
        vecs[16] = '{1'b0,1'b1,1'b1,4'd15,1'b0,1'b0,4'd0, 1'b1};
        vecs[17] = '{1'b0,1'b1,1'b1,4'd10,1'b1,1'b0,4'd0, 1'b1};
        vecs[18] = '{1'b0,1'b1,1'b0,4'd0, 1'b1,1'b0,4'd0, 1'b0};
        vecs[19] = '{1'b0,1'b1,1'b1,4'd9, 1'b0,1'b0,4'd9, 1'b0};

        // Reset state
        #12;
        chk("reset_q",   32'(bus.q),   32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
        chk("reset_tc",  32'(bus.tc),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv, vecs[i].clr);
            #2;
            chk($sformatf("vec%0d_tc", i), 32'(bus.tc), 32'(vecs[i].tc));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_q", i),   32'(bus.q),   32'(vecs[i].q));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
        end

        // Cell commands at q=3 counting up: bits 0..2 toggle, bit 3 holds
        drive(1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        @(posedge clk);
        #1;
        chk("load3_q", 32'(bus.q), 32'd3);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        #2;
        chk("jk_3to4", 32'(dut.w_jk), 32'h3F);
        @(posedge clk);
        #1;
        chk("count_q4", 32'(bus.q), 32'd4);

        // en=0: every cell holds and q stays put for 5 cycles
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        held = bus.q;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("hold_jk%0d", c), 32'(dut.w_jk), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("hold_q%0d", c), 32'(bus.q), 32'd4);
        end
        chk("hold_same", 32'(bus.q), 32'(held));

        // Reset mid-count: get ovf set, count 0..7, then pulse rst between edges
        drive(1'b0, 1'b1, 1'b1, 4'd12, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_ovf", 32'(bus.ovf), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_q7", 32'(bus.q), 32'd7);
        #2;
        bus.up = 1'b0;           // q=0 with down count would raise tc if rst did not mask it
        rst    = 1'b1;
        #1;
        chk("async_rst_q",   32'(bus.q),   32'd0);
        chk("async_rst_ovf", 32'(bus.ovf), 32'd0);
        chk("async_rst_tc",  32'(bus.tc),  32'd0);
        #1;
        rst    = 1'b0;
        bus.up = 1'b1;
        #1;
        chk("post_rst_q0", 32'(bus.q), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_q1", 32'(bus.q), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_q2", 32'(bus.q), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jk_mod_counter
`default_nettype wire
